// File: rtl/sw_debouncer_pkg.sv
// sw_debouncer_pkg: shared defaults, per-bit state encoding and width helper
package sw_debouncer_pkg;
   localparam int SW_WIDTH_DEFAULT      = 9;
   localparam int TICK_DIV_DEFAULT      = 50000;
   localparam int STABLE_CYCLES_DEFAULT = 4;
   typedef enum logic {STABLE = 1'b0, PENDING = 1'b1} db_state_t;
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/sw_debouncer_if.sv
// sw_debouncer_if: raw switch input plus debounced levels and strobes
interface sw_debouncer_if import sw_debouncer_pkg::*; #(parameter int WIDTH = SW_WIDTH_DEFAULT);
   logic [WIDTH-1:0] sw_raw;
   logic [WIDTH-1:0] sw_out;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic             changed;
   logic             tick;
   modport master (output sw_raw, input sw_out, rise, fall, changed, tick);
   modport slave  (input sw_raw, output sw_out, rise, fall, changed, tick);
endinterface

// File: rtl/sw_debouncer_bit.sv
// debounce_bit: two-flop synchroniser, tick-gated debounce FSM and rise/fall strobes for one switch
module debounce_bit import sw_debouncer_pkg::*; #(
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic sw_raw,
   output logic sw_out,
   output logic rise,
   output logic fall
);
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   logic          s1, s2, accept;
   db_state_t     state, state_nx;
   logic [CW-1:0] count, count_nx, inc;
   always_ff @(posedge clk) begin
      if (rst) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         state  <= STABLE;
         count  <= '0;
         sw_out <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         s1     <= sw_raw;
         s2     <= s1;
         state  <= state_nx;
         count  <= count_nx;
         sw_out <= accept ? s2 : sw_out;
         rise   <= accept & s2;
         fall   <= accept & ~s2;
      end
   end
   // a first mismatch from STABLE counts as 1, so STABLE_CYCLES==1 accepts at once
   always_comb begin
      state_nx = state;
      count_nx = count;
      accept   = 1'b0;
      inc      = (state == PENDING) ? count + CW'(1) : CW'(1);
      if (tick) begin
         if (s2 == sw_out) begin
            state_nx = STABLE;
            count_nx = '0;
         end else if (inc == CW'(STABLE_CYCLES)) begin
            accept   = 1'b1;
            state_nx = STABLE;
            count_nx = '0;
         end else begin
            state_nx = PENDING;
            count_nx = inc;
         end
      end
   end
endmodule

// File: rtl/sw_debouncer.sv
// sw_debouncer: sample-tick generator plus per-bit debouncers between board switches and the CPU
module sw_debouncer import sw_debouncer_pkg::*; #(
   parameter int WIDTH         = SW_WIDTH_DEFAULT,
   parameter int TICK_DIV      = TICK_DIV_DEFAULT,
   parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
   input logic            clk,
   input logic            rst,
   sw_debouncer_if.slave  bus
);
   localparam int TW = cnt_width(TICK_DIV);
   logic [TW-1:0]    tick_cnt;
   logic             tick_q, last;
   logic [WIDTH-1:0] sw_out_v, rise_v, fall_v;
   assign last = (tick_cnt == TW'(TICK_DIV - 1));
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt <= '0;
         tick_q   <= 1'b0;
      end else begin
         tick_cnt <= last ? '0 : tick_cnt + TW'(1);
         tick_q   <= last;
      end
   end
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(.STABLE_CYCLES(STABLE_CYCLES)) u_bit (
         .clk    (clk),
         .rst    (rst),
         .tick   (tick_q),
         .sw_raw (bus.sw_raw[i]),
         .sw_out (sw_out_v[i]),
         .rise   (rise_v[i]),
         .fall   (fall_v[i])
      );
   end
   assign bus.tick    = tick_q;
   assign bus.sw_out  = sw_out_v;
   assign bus.rise    = rise_v;
   assign bus.fall    = fall_v;
   assign bus.changed = |(rise_v | fall_v);
endmodule

// File: tb/tb_sw_debouncer.sv
// tb_sw_debouncer: directed vectors against two debouncer configurations
module tb_sw_debouncer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0, n_err = 0;
   int   t_first, n_chg, tot_chg;
   logic [8:0] rise_acc, fall_acc, rise_at, fall_at, rf_acc, early;
   sw_debouncer_if #(.WIDTH(9)) bus_a ();
   sw_debouncer_if #(.WIDTH(9)) bus_b ();
   sw_debouncer #(.WIDTH(9), .TICK_DIV(4), .STABLE_CYCLES(3)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   sw_debouncer #(.WIDTH(9), .TICK_DIV(1), .STABLE_CYCLES(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic run(input int n);
      logic [8:0] prev;
      t_first = -1; n_chg = 0;
      rise_acc = '0; fall_acc = '0; rise_at = '0; fall_at = '0;
      for (int k = 1; k <= n; k++) begin
         prev = bus_a.sw_out;
         step();
         if (bus_a.changed) n_chg++;
         rise_acc |= bus_a.rise;
         fall_acc |= bus_a.fall;
         if (bus_a.sw_out !== prev && t_first < 0) begin
            t_first = k;
            rise_at = bus_a.rise;
            fall_at = bus_a.fall;
         end
      end
   endtask
   initial begin
      bus_a.sw_raw = '0;
      bus_b.sw_raw = '0;
      repeat (3) step();
      chk("rst_sw_out", 32'(bus_a.sw_out), 0);
      chk("rst_strobes", 32'(bus_a.rise | bus_a.fall), 0);
      chk("rst_changed", 32'(bus_a.changed), 0);
      chk("rst_tick_a", 32'(bus_a.tick), 0);
      chk("rst_tick_b", 32'(bus_b.tick), 0);
      rst = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         step();
         chk($sformatf("tick_a_c%0d", k), 32'(bus_a.tick), 32'(k % 4 == 0));
         chk($sformatf("tick_b_c%0d", k), 32'(bus_b.tick), 1);
      end
      bus_a.sw_raw = 9'h001;
      run(20);
      chk("step_latency_in_range", 32'(t_first >= 11 && t_first <= 15), 1);
      chk("step_sw_out", 32'(bus_a.sw_out), 32'h001);
      chk("step_rise_at_change", 32'(rise_at), 32'h001);
      chk("step_changed_pulses", 32'(n_chg), 1);
      chk("step_fall_none", 32'(fall_acc), 0);
      bus_a.sw_raw = '0;
      run(20);
      chk("release_fall", 32'(fall_at), 32'h001);
      chk("release_sw_out", 32'(bus_a.sw_out), 0);
      tot_chg = 0; rf_acc = '0;
      for (int p = 0; p < 8; p++) begin
         bus_a.sw_raw = (p % 2 == 0) ? 9'h008 : 9'h000;
         run(5);
         tot_chg += n_chg;
         rf_acc |= rise_acc | fall_acc | bus_a.sw_out;
      end
      bus_a.sw_raw = '0;
      run(20);
      tot_chg += n_chg;
      rf_acc |= rise_acc | fall_acc | bus_a.sw_out;
      chk("bounce0_changed", 32'(tot_chg), 0);
      chk("bounce0_activity", 32'(rf_acc), 0);
      tot_chg = 0; rf_acc = '0;
      for (int p = 0; p < 8; p++) begin
         bus_a.sw_raw = (p % 2 == 0) ? 9'h008 : 9'h000;
         run(5);
         tot_chg += n_chg;
         rf_acc |= rise_acc | fall_acc | bus_a.sw_out;
      end
      bus_a.sw_raw = 9'h008;
      run(20);
      chk("bounce1_quiet_while_toggling", 32'(rf_acc), 0);
      chk("bounce1_sw_out", 32'(bus_a.sw_out), 32'h008);
      chk("bounce1_changed", 32'(tot_chg + n_chg), 1);
      chk("bounce1_rise", 32'(rise_acc), 32'h008);
      bus_a.sw_raw = '0;
      run(20);
      bus_a.sw_raw = 9'h1FF;
      run(20);
      chk("all_sw_out", 32'(bus_a.sw_out), 32'h1FF);
      chk("all_rise_at_change", 32'(rise_at), 32'h1FF);
      chk("all_changed", 32'(n_chg), 1);
      chk("all_fall_none", 32'(fall_acc), 0);
      bus_a.sw_raw = 9'h0AA;
      run(20);
      chk("aa_sw_out", 32'(bus_a.sw_out), 32'h0AA);
      chk("aa_fall_at_change", 32'(fall_at), 32'h155);
      chk("aa_rise_none", 32'(rise_acc), 0);
      chk("aa_changed", 32'(n_chg), 1);
      bus_a.sw_raw = '0;
      run(20);
      for (int k = 0; k < 10 && !bus_a.tick; k++) step();
      chk("midrst_tick_found", 32'(bus_a.tick), 1);
      bus_a.sw_raw = 9'h001;
      repeat (9) step();
      chk("midrst_not_yet", 32'(bus_a.sw_out), 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_sw_out", 32'(bus_a.sw_out), 0);
      chk("midrst_strobes", 32'(bus_a.rise | bus_a.fall), 0);
      chk("midrst_changed", 32'(bus_a.changed), 0);
      chk("midrst_tick", 32'(bus_a.tick), 0);
      early = '0;
      for (int k = 0; k < 12; k++) begin
         step();
         early |= bus_a.sw_out | bus_a.rise;
      end
      chk("midrst_never_early", 32'(early), 0);
      step();
      chk("midrst_accept", 32'(bus_a.sw_out), 32'h001);
      chk("midrst_rise", 32'(bus_a.rise), 32'h001);
      bus_a.sw_raw = '0;
      run(20);
      bus_a.sw_raw = 9'h020;
      step();
      bus_a.sw_raw = '0;
      run(20);
      chk("glitch_a_no_change", 32'(t_first), 32'hFFFF_FFFF);
      chk("glitch_a_no_strobe", 32'(n_chg), 0);
      bus_b.sw_raw = 9'h020;
      step();
      bus_b.sw_raw = '0;
      step();
      chk("glitch_b_c2_out", 32'(bus_b.sw_out), 0);
      step();
      chk("glitch_b_c3_out", 32'(bus_b.sw_out), 32'h020);
      chk("glitch_b_c3_rise", 32'(bus_b.rise), 32'h020);
      chk("glitch_b_c3_changed", 32'(bus_b.changed), 1);
      step();
      chk("glitch_b_c4_out", 32'(bus_b.sw_out), 0);
      chk("glitch_b_c4_fall", 32'(bus_b.fall), 32'h020);
      chk("glitch_b_c4_rise", 32'(bus_b.rise), 0);
      step();
      chk("glitch_b_c5_quiet", 32'(bus_b.changed), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/sw_debouncer.md
Name: sw_debouncer

Overview:
Input-side counterpart to the LED/hex output path. Conditions raw board switches before they reach the CPU `in` port.
- Synchronises each switch bit into the `clk` domain.
- Debounces it against a slow sample tick.
- Presents a stable switch vector plus one-cycle rise/fall/changed strobes.
- Sits between the board `sw` pins and the CPU input; replaces direct wiring of `sw` into the core.

Parameters:
- WIDTH, 9, number of switch bits.
- TICK_DIV, 50000, `clk` cycles per sample tick; must be >= 1.
- STABLE_CYCLES, 4, consecutive mismatching sample ticks needed to accept a new level; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- sw_raw  input  WIDTH  asynchronous raw switch levels.
- sw_out  output  WIDTH  debounced switch levels.
- rise  output  WIDTH  one-cycle pulse per bit on an accepted 0->1 change.
- fall  output  WIDTH  one-cycle pulse per bit on an accepted 1->0 change.
- changed  output  1  one-cycle pulse, equal to the OR of rise|fall.
- tick  output  1  sample strobe, exported for reuse and for the bench.

Behaviour:
- Single clock domain. Reset is sampled only on the `clk` rising edge; the highest-priority action each cycle.
- Reset values: sync stages 0, tick counter 0, tick 0, all per-bit counters 0, sw_out 0, rise 0, fall 0, changed 0.
- Synchroniser: two flops per bit, sw_raw -> s1 -> s2. s2 is the "synced" level, 2 cycles after sw_raw.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick is registered: high for exactly one cycle on the cycle after the counter reaches TICK_DIV-1.
  - The first tick after reset release is at cycle TICK_DIV. With TICK_DIV=1, tick is high every cycle after the first.
- Per-bit FSM, evaluated only on cycles where tick=1:
  - States: STABLE (s2 == sw_out) and PENDING (s2 != sw_out, count > 0).
  - STABLE, tick, s2 != sw_out: count <= 1. If STABLE_CYCLES == 1, accept immediately; otherwise go to PENDING.
  - PENDING, tick, s2 != sw_out: count <= count+1. When count+1 == STABLE_CYCLES, accept and return to STABLE with count 0.
  - PENDING, tick, s2 == sw_out (bounce): count <= 0 and return to STABLE. No output change.
  - Non-tick cycles: state and count hold.
- Accept action (registered, same cycle for all affected bits):
  - sw_out[i] <= s2[i].
  - rise[i] or fall[i] pulses for exactly one cycle, chosen by direction.
  - changed pulses in that same cycle.
- Strobes are 0 on every cycle without an accept. Simultaneous accepts on multiple bits produce one changed pulse.
- Latency from a clean sw_raw step to sw_out: 2 sync cycles plus STABLE_CYCLES ticks.
  - Bounded by 2 + (STABLE_CYCLES-1)*TICK_DIV + 1 (min) and 2 + STABLE_CYCLES*TICK_DIV + 1 (max).
- Glitches shorter than one tick interval, or bounce streaks shorter than STABLE_CYCLES ticks, never reach sw_out.
- Reset mid-operation: all pending counts are discarded and sw_out returns to 0. A switch held high through reset is accepted again after the full latency, with a rise pulse.
- Width rules: count width is $clog2(STABLE_CYCLES+1); tick counter width is $clog2(TICK_DIV) (minimum 1). Saturation is never reached because count clears on accept.

Decomposition:
- Shared package: SW_WIDTH_DEFAULT=9, TICK_DIV_DEFAULT=50000, STABLE_CYCLES_DEFAULT=4, and the per-bit state encoding (STABLE=0, PENDING=1).
- One natural sub-module, debounce_bit: synchroniser, FSM, counter and strobes for one bit, with tick as an input. It is instantiated WIDTH times by a generate loop.
- The tick generator and the changed OR stay in sw_debouncer.

Test Plan (TICK_DIV=4, STABLE_CYCLES=3 unless noted):
- Clean step: sw_raw 0x000 -> 0x001 held.
  - sw_out becomes 0x001 between 11 and 15 cycles after the step.
  - rise=0x001 and changed=1 for exactly that one cycle; fall stays 0.
- Bounce: bit 3 toggles every 5 cycles for 40 cycles, then is held 0.
  - sw_out stays 0x000; rise, fall and changed are never asserted.
  - Held 1 instead: sw_out becomes 0x008 with a single rise pulse.
- All bits: sw_raw 0x000 -> 0x1FF, then later -> 0x0AA.
  - First change: sw_out 0x1FF, rise=0x1FF on one cycle, one changed pulse.
  - Second change: sw_out 0x0AA, fall=0x155 on one cycle, rise=0.
- Reset mid-count: after 2 mismatching ticks on bit 0, assert rst for 1 cycle.
  - All outputs are 0 on the cycle after reset.
  - sw_out[0] is accepted only after 3 further ticks (never early).
- Single-cycle glitch: bit 5 high for 1 cycle.
  - With STABLE_CYCLES=3: no change on sw_out and no strobes.
  - With STABLE_CYCLES=1 and TICK_DIV=1: sw_out[5] rises 3 cycles after the glitch, then falls with a fall pulse exactly one cycle later.
- Tick cadence: after rst release, tick pulses at cycles 4, 8, 12, each one cycle wide.
  - With TICK_DIV=1, tick=1 on every cycle from cycle 1.
